// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with saturating
// direction counters. Gives a zero-latency taken/target prediction for the
// fetch PC. It is trained by the resolve stage and keeps saturating
// branch and mispredict statistics.
module branch_predictor #(
  parameter int ADDR_W  = 16,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  // Weakly-not-taken / weakly-taken sit just either side of the MSB flip.
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CNT_W-1:0]  cnt_q   [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic [CNT_W-1:0]  upd_cnt;
  logic [CNT_W-1:0]  upd_cnt_next;
  logic              upd_write;

  assign lk_idx  = lk_pc[IDX_W-1:0];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W];
  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index shows up one cycle later.
  assign pred_hit    = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit & cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : lk_pc + ADDR_W'(1);

  assign mispredict = upd_valid &
                      ((upd_taken != upd_pred_taken) |
                       (upd_taken & (upd_pred_target != upd_target)));

  assign upd_hit   = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_cnt   = cnt_q[upd_idx];
  assign upd_write = en & upd_valid & ~clear;

  // Saturating step of the counter held at the updated index.
  always_comb begin
    upd_cnt_next = upd_cnt;
    if (upd_taken) begin
      if (upd_cnt != CNT_MAX) upd_cnt_next = upd_cnt + CNT_W'(1);
    end else begin
      if (upd_cnt != '0) upd_cnt_next = upd_cnt - CNT_W'(1);
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic              v_q;
    logic [TAG_W-1:0]  t_q;
    logic [ADDR_W-1:0] a_q;
    logic [CNT_W-1:0]  c_q;
    logic              sel;

    assign sel = upd_write & (upd_idx == IDX_W'(i));

    // Per-entry state: clear invalidates everything, otherwise train or allocate.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        t_q <= '0;
        a_q <= '0;
        c_q <= CNT_WNT;
      end else if (en && clear) begin
        v_q <= 1'b0;
        c_q <= CNT_WNT;
      end else if (sel) begin
        if (upd_hit) begin
          c_q <= upd_cnt_next;
          if (upd_taken) a_q <= upd_target;
        end else if (upd_taken) begin
          v_q <= 1'b1;
          t_q <= upd_tag;
          a_q <= upd_target;
          c_q <= CNT_WT;
        end
      end
    end

    assign valid_q[i] = v_q;
    assign tag_q[i]   = t_q;
    assign tgt_q[i]   = a_q;
    assign cnt_q[i]   = c_q;
  end

  // Statistics count every resolved branch, including those that arrive
  // alongside a clear; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (en && upd_valid) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + STAT_W'(1);
      if (mispredict && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with hand-computed expectations,
// queued by the driver and checked by an independent monitor at negedge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clear;
  logic [15:0] lk_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        pred_hit;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        upd_pred_taken;
  logic [15:0] upd_pred_target;
  logic        mispredict;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        hit;
    logic        tkn;
    logic [15:0] tgt;
    logic        mp;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t sb[$];

  branch_predictor #(
    .ADDR_W(16), .ENTRIES(16), .CNT_W(2), .STAT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .lk_pc(lk_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are stable by the falling edge; compare one expectation per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".pred_hit"},       32'(pred_hit),       32'(e.hit));
      chk({e.nm, ".pred_taken"},     32'(pred_taken),     32'(e.tkn));
      chk({e.nm, ".pred_target"},    32'(pred_target),    32'(e.tgt));
      chk({e.nm, ".mispredict"},     32'(mispredict),     32'(e.mp));
      chk({e.nm, ".branch_cnt"},     32'(branch_cnt),     32'(e.bc));
      chk({e.nm, ".mispredict_cnt"}, 32'(mispredict_cnt), 32'(e.mc));
    end
  end

  task automatic push(input string nm, input logic eh, input logic et, input logic [15:0] etgt,
                      input logic emp, input logic [15:0] ebc, input logic [15:0] emc);
    exp_t e;
    e.nm = nm; e.hit = eh; e.tkn = et; e.tgt = etgt;
    e.mp = emp; e.bc = ebc; e.mc = emc;
    sb.push_back(e);
  endtask

  // One cycle: inputs applied just after posedge, expected outputs for that cycle queued.
  task automatic vec(input string nm, input logic e, input logic c, input logic [15:0] lk,
                     input logic uv, input logic [15:0] upc, input logic ut,
                     input logic [15:0] utgt, input logic upt, input logic [15:0] uptgt,
                     input logic eh, input logic et, input logic [15:0] etgt,
                     input logic emp, input logic [15:0] ebc, input logic [15:0] emc);
    @(posedge clk);
    #1;
    en = e; clear = c; lk_pc = lk;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt;
    push(nm, eh, et, etgt, emp, ebc, emc);
  endtask

  task automatic look(input string nm, input logic [15:0] lk, input logic eh, input logic et,
                      input logic [15:0] etgt, input logic [15:0] ebc, input logic [15:0] emc);
    vec(nm, 1'b1, 1'b0, lk, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0,
        eh, et, etgt, 1'b0, ebc, emc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; clear = 1'b0; lk_pc = 16'h0;
    upd_valid = 1'b0; upd_pc = 16'h0; upd_taken = 1'b0; upd_target = 16'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    look("rst_lk5",    16'h0005, 1'b0, 1'b0, 16'h0006, 16'd0, 16'd0);
    look("rst_lkffff", 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0);

    // First allocation; same-cycle lookup sees the old (empty) entry
    vec("alloc5", 1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0006,
        1'b0, 1'b0, 16'h0006, 1'b1, 16'd0, 16'd0);
    look("alloc5_hit", 16'h0005, 1'b1, 1'b1, 16'h0040, 16'd1, 16'd1);

    // Counter walk: 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
    vec("nt1", 1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0040,
        1'b1, 1'b1, 16'h0040, 1'b1, 16'd1, 16'd1);
    vec("nt2", 1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0006,
        1'b1, 1'b0, 16'h0006, 1'b0, 16'd2, 16'd2);
    vec("t1",  1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0006,
        1'b1, 1'b0, 16'h0006, 1'b1, 16'd3, 16'd2);
    vec("t2",  1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0006,
        1'b1, 1'b0, 16'h0006, 1'b1, 16'd4, 16'd3);
    vec("t3",  1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b1, 16'h0040,
        1'b1, 1'b1, 16'h0040, 1'b0, 16'd5, 16'd4);
    vec("t_sat", 1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b1, 16'h0040,
        1'b1, 1'b1, 16'h0040, 1'b0, 16'd6, 16'd4);
    vec("nt3", 1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0040,
        1'b1, 1'b1, 16'h0040, 1'b1, 16'd7, 16'd4);
    look("still_taken", 16'h0005, 1'b1, 1'b1, 16'h0040, 16'd8, 16'd5);
    vec("nt4", 1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0040,
        1'b1, 1'b1, 16'h0040, 1'b1, 16'd8, 16'd5);
    look("now_nt", 16'h0005, 1'b1, 1'b0, 16'h0006, 16'd9, 16'd6);

    // Aliasing on index 5
    look("alias_miss", 16'h0015, 1'b0, 1'b0, 16'h0016, 16'd9, 16'd6);
    vec("alias_nt", 1'b1, 1'b0, 16'h0015, 1'b1, 16'h0015, 1'b0, 16'h0000, 1'b0, 16'h0016,
        1'b0, 1'b0, 16'h0016, 1'b0, 16'd9, 16'd6);
    look("alias_keep5", 16'h0005, 1'b1, 1'b0, 16'h0006, 16'd10, 16'd6);
    vec("alias_t", 1'b1, 1'b0, 16'h0015, 1'b1, 16'h0015, 1'b1, 16'h0100, 1'b0, 16'h0016,
        1'b0, 1'b0, 16'h0016, 1'b1, 16'd10, 16'd6);
    look("alias_hit15", 16'h0015, 1'b1, 1'b1, 16'h0100, 16'd11, 16'd7);
    look("alias_miss5", 16'h0005, 1'b0, 1'b0, 16'h0006, 16'd11, 16'd7);

    // Target change on a hit
    vec("tgt_chg", 1'b1, 1'b0, 16'h0015, 1'b1, 16'h0015, 1'b1, 16'h0150, 1'b1, 16'h0100,
        1'b1, 1'b1, 16'h0100, 1'b1, 16'd11, 16'd7);
    look("tgt_new", 16'h0015, 1'b1, 1'b1, 16'h0150, 16'd12, 16'd8);

    // en=0: mispredict still live, nothing committed
    vec("en0", 1'b0, 1'b0, 16'h0015, 1'b1, 16'h0015, 1'b1, 16'h0200, 1'b1, 16'h0150,
        1'b1, 1'b1, 16'h0150, 1'b1, 16'd12, 16'd8);
    look("en0_after", 16'h0015, 1'b1, 1'b1, 16'h0150, 16'd12, 16'd8);

    // clear beats a same-cycle update; statistics still count it
    vec("clear_upd", 1'b1, 1'b1, 16'h0015, 1'b1, 16'h0025, 1'b1, 16'h0300, 1'b0, 16'h0026,
        1'b1, 1'b1, 16'h0150, 1'b1, 16'd12, 16'd8);
    look("clr_miss15", 16'h0015, 1'b0, 1'b0, 16'h0016, 16'd13, 16'd9);
    look("clr_miss25", 16'h0025, 1'b0, 1'b0, 16'h0026, 16'd13, 16'd9);

    // Repopulate, then async reset between edges
    vec("realloc", 1'b1, 1'b0, 16'h0015, 1'b1, 16'h0015, 1'b1, 16'h0150, 1'b0, 16'h0016,
        1'b0, 1'b0, 16'h0016, 1'b1, 16'd13, 16'd9);
    look("realloc_hit", 16'h0015, 1'b1, 1'b1, 16'h0150, 16'd14, 16'd10);
    @(posedge clk);
    #1;
    lk_pc = 16'h0015; upd_valid = 1'b0;
    #2 rst = 1'b1;
    push("rst_async", 1'b0, 1'b0, 16'h0016, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // First update after reset release is accepted
    vec("post_rst", 1'b1, 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0006,
        1'b0, 1'b0, 16'h0006, 1'b1, 16'd0, 16'd0);
    look("post_rst_hit", 16'h0005, 1'b1, 1'b1, 16'h0040, 16'd1, 16'd1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
